eaf_request_sequencer: RTL and testbench

Sequencer that sits directly upstream of the eviction address filter, between the cache controller and the filter. It accepts eviction events (addresses to insert) and miss-fill events (addresses to test) from the cache and holds them in one in-order queue. It issues them to the filter one at a time over a level-held request / response handshake. For each test it returns the filter's insertion priority and hit flag to the cache, and it abandons any request the filter fails to answer within a bounded time.

---
 rtl/eaf_request_sequencer_if.sv | 36 +++
 rtl/eaf_request_sequencer.sv | 117 +++++++++++
 tb/tb_eaf_request_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/eaf_request_sequencer_if.sv
// Cache-side and filter-side handshake bundle for the eviction address filter sequencer.
interface eaf_request_sequencer_if #(
  parameter int addr_length = 32
);
  logic                   evict_valid;
  logic [addr_length-1:0] evict_addr;
  logic                   evict_ready;
  logic                   fill_valid;
  logic [addr_length-1:0] fill_addr;
  logic                   fill_ready;
  logic                   fill_done;
  logic [addr_length-1:0] fill_done_addr;
  logic                   fill_priority;
  logic                   fill_hit;
  logic [addr_length-1:0] eaf_addr;
  logic                   eaf_insert;
  logic                   eaf_test;
  logic                   eaf_resp;
  logic                   eaf_priority;
  logic                   eaf_exists;
  logic                   timeout_err;

  modport slave (
    input  evict_valid, evict_addr, fill_valid, fill_addr,
           eaf_resp, eaf_priority, eaf_exists,
    output evict_ready, fill_ready, fill_done, fill_done_addr, fill_priority, fill_hit,
           eaf_addr, eaf_insert, eaf_test, timeout_err
  );

  modport master (
    output evict_valid, evict_addr, fill_valid, fill_addr,
           eaf_resp, eaf_priority, eaf_exists,
    input  evict_ready, fill_ready, fill_done, fill_done_addr, fill_priority, fill_hit,
           eaf_addr, eaf_insert, eaf_test, timeout_err
  );
endinterface

// File: rtl/eaf_request_sequencer.sv
// In-order queue of insert/test requests issued one at a time to the eviction
// address filter, with per-request response timeout.
module eaf_request_sequencer #(
  parameter int addr_length = 32,
  parameter int queue_depth = 4,
  parameter int max_wait    = 15
) (
  input logic                   clk,
  input logic                   rst,
  eaf_request_sequencer_if.slave bus
);
  localparam int PW = $clog2(queue_depth);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(max_wait + 1);

  typedef struct packed {
    logic                   test;
    logic [addr_length-1:0] addr;
  } entry_t;

  typedef enum logic {IDLE, REQ} state_t;

  entry_t        mem [queue_depth];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ready, push_e, push_f, pop;
  state_t        state, state_n;
  logic [WW-1:0] wait_cnt, wait_n;
  entry_t        hold;
  logic          ins_n, tst_n, done_n, terr_n, prio_n, hit_n;

  // Two free slots are always kept so an evict and a fill can land together.
  assign ready           = (count <= CW'(queue_depth - 2));
  assign bus.evict_ready = ready;
  assign bus.fill_ready  = ready;
  assign push_e          = bus.evict_valid & ready;
  assign push_f          = bus.fill_valid & ready;
  assign bus.eaf_addr    = hold.addr;

  // Eviction takes the lower slot so its insert precedes a same-cycle test.
  always_ff @(posedge clk) begin
    if (push_e) mem[wr_ptr] <= {1'b0, bus.evict_addr};
    if (push_f) mem[wr_ptr + PW'(push_e)] <= {1'b1, bus.fill_addr};
  end

  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    pop     = 1'b0;
    ins_n   = 1'b0;
    tst_n   = 1'b0;
    done_n  = 1'b0;
    terr_n  = 1'b0;
    prio_n  = 1'b0;
    hit_n   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_n = REQ;
          wait_n  = '0;
          ins_n   = ~mem[rd_ptr].test;
          tst_n   = mem[rd_ptr].test;
        end
      end
      REQ: begin
        if (bus.eaf_resp) begin
          state_n = IDLE;
          done_n  = hold.test;
          prio_n  = hold.test & bus.eaf_priority;
          hit_n   = hold.test & bus.eaf_exists;
        end else if (wait_cnt == WW'(max_wait)) begin
          state_n = IDLE;
          terr_n  = 1'b1;
          done_n  = hold.test;
        end else begin
          wait_n = wait_cnt + 1'b1;
          ins_n  = ~hold.test;
          tst_n  = hold.test;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      state              <= IDLE;
      wait_cnt           <= '0;
      hold               <= '0;
      bus.eaf_insert     <= 1'b0;
      bus.eaf_test       <= 1'b0;
      bus.fill_done      <= 1'b0;
      bus.fill_done_addr <= '0;
      bus.fill_priority  <= 1'b0;
      bus.fill_hit       <= 1'b0;
      bus.timeout_err    <= 1'b0;
    end else begin
      wr_ptr            <= wr_ptr + PW'(push_e) + PW'(push_f);
      rd_ptr            <= rd_ptr + PW'(pop);
      count             <= count + CW'(push_e) + CW'(push_f) - CW'(pop);
      state             <= state_n;
      wait_cnt          <= wait_n;
      if (pop) hold     <= mem[rd_ptr];
      bus.eaf_insert    <= ins_n;
      bus.eaf_test      <= tst_n;
      bus.fill_done     <= done_n;
      bus.fill_priority <= prio_n;
      bus.fill_hit      <= hit_n;
      bus.timeout_err   <= terr_n;
      if (done_n) bus.fill_done_addr <= hold.addr;
    end
  end
endmodule

// File: tb/tb_eaf_request_sequencer.sv
// Randomized scoreboard bench: cache driver, filter responder model and monitor.
module tb_eaf_request_sequencer;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int MAXW  = 15;

  typedef struct { bit typ; logic [AW-1:0] addr; } req_t;
  typedef struct { bit resp; int d; bit prio; bit hit; } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  bit   filt_stall = 1'b0;
  req_t exp_req[$];
  out_t exp_out[$];

  eaf_request_sequencer_if #(.addr_length(AW)) bif ();

  eaf_request_sequencer #(.addr_length(AW), .queue_depth(DEPTH), .max_wait(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cache side: one cycle per call, entered and left at posedge+1.
  task automatic step(input bit ev, input logic [AW-1:0] ea, input bit fv, input logic [AW-1:0] fa);
    bit ae, af;
    bif.evict_valid = ev;
    bif.evict_addr  = ea;
    bif.fill_valid  = fv;
    bif.fill_addr   = fa;
    @(negedge clk);
    ae = ev & bif.evict_ready;
    af = fv & bif.fill_ready;
    @(posedge clk);
    if (ae) exp_req.push_back('{1'b0, ea});
    if (af) exp_req.push_back('{1'b1, fa});
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_req.size() > 0 || exp_out.size() > 0 || bif.eaf_insert || bif.eaf_test) && n < budget) begin
      step(1'b0, '0, 1'b0, '0);
      n++;
    end
    chk("drain_left", exp_req.size() + exp_out.size(), 0);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    return ($urandom_range(3) == 0) ? 32'h0000_00A0 : $urandom;
  endfunction

  // Filter model: chooses a response delay or no response for each request.
  initial begin : filter
    bit   prev, cur;
    int   cnt;
    out_t o;
    prev = 1'b0;
    cnt  = 0;
    o    = '{1'b0, 0, 1'b0, 1'b0};
    bif.eaf_resp     = 1'b0;
    bif.eaf_priority = 1'b0;
    bif.eaf_exists   = 1'b0;
    forever begin
      @(negedge clk);
      bif.eaf_resp     = 1'b0;
      bif.eaf_priority = 1'($urandom_range(1));
      bif.eaf_exists   = 1'($urandom_range(1));
      if (!rst) begin
        prev = 1'b0;
        cnt  = 0;
      end else begin
        cur = bif.eaf_insert | bif.eaf_test;
        if (cur && !prev) begin
          o.resp = !filt_stall && ($urandom_range(7) != 0);
          o.d    = $urandom_range(1, 4);
          o.prio = 1'($urandom_range(1));
          o.hit  = 1'($urandom_range(1));
          exp_out.push_back(o);
          cnt = o.resp ? o.d : -1;
        end
        if (cur && cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bif.eaf_resp     = 1'b1;
            bif.eaf_priority = o.prio;
            bif.eaf_exists   = o.hit;
          end
        end
        // Late answer after an abandoned request must be ignored.
        if (!cur && prev && !o.resp && !filt_stall && $urandom_range(1) == 1) bif.eaf_resp = 1'b1;
        prev = cur;
      end
    end
  end

  initial begin : monitor
    bit          prev, cur, pend;
    int          hi;
    req_t        r;
    out_t        o;
    logic [AW-1:0] a0;
    prev = 1'b0;
    pend = 1'b0;
    hi   = 0;
    r    = '{1'b0, '0};
    a0   = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b0;
        pend = 1'b0;
        hi   = 0;
      end else begin
        cur = bif.eaf_insert | bif.eaf_test;
        if (cur && !prev) begin
          chk("req_expected", exp_req.size() > 0, 1);
          if (exp_req.size() > 0) begin
            r = exp_req.pop_front();
            chk("req_kind", {bif.eaf_insert, bif.eaf_test}, r.typ ? 2'b01 : 2'b10);
            chk("req_addr", bif.eaf_addr, r.addr);
          end
          a0 = bif.eaf_addr;
          hi = 0;
        end
        if (pend) chk("start_latency", cur, 1);
        if (cur) begin
          hi++;
          chk("addr_stable", bif.eaf_addr, a0);
          chk("req_exclusive", bif.eaf_insert & bif.eaf_test, 0);
        end
        if (!cur && prev) begin
          chk("outcome_expected", exp_out.size() > 0, 1);
          if (exp_out.size() > 0) begin
            o = exp_out.pop_front();
            chk("req_len", hi, o.resp ? o.d : MAXW + 1);
            chk("timeout_err", bif.timeout_err, !o.resp);
            chk("fill_done", bif.fill_done, r.typ);
            if (r.typ) begin
              chk("fill_done_addr", bif.fill_done_addr, r.addr);
              chk("fill_priority", bif.fill_priority, o.resp & o.prio);
              chk("fill_hit", bif.fill_hit, o.resp & o.hit);
            end
          end
        end else begin
          chk("no_stray_pulse", {bif.fill_done, bif.timeout_err}, 2'b00);
        end
        chk("ready", {bif.evict_ready, bif.fill_ready}, (exp_req.size() <= DEPTH - 2) ? 2'b11 : 2'b00);
        pend = !cur && exp_req.size() > 0;
        prev = cur;
      end
    end
  end

  initial begin : stim
    bif.evict_valid = 1'b0;
    bif.evict_addr  = '0;
    bif.fill_valid  = 1'b0;
    bif.fill_addr   = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", |{bif.fill_done, bif.fill_done_addr, bif.fill_priority, bif.fill_hit,
                           bif.eaf_addr, bif.eaf_insert, bif.eaf_test, bif.timeout_err}, 0);
    chk("reset_ready", {bif.evict_ready, bif.fill_ready}, 2'b11);
    @(posedge clk);
    #1 rst = 1'b1;

    // Same-cycle evict and fill of one address, then a single test.
    step(1'b1, 32'h0000_00A0, 1'b1, 32'h0000_00A0);
    step(1'b0, '0, 1'b1, 32'h0000_1040);
    drain(200);

    // Unanswered test runs to timeout.
    filt_stall = 1'b1;
    step(1'b0, '0, 1'b1, 32'h0000_0055);
    drain(200);
    filt_stall = 1'b0;
    repeat (3) step(1'b0, '0, 1'b0, '0);

    for (int i = 0; i < 2000; i++) begin
      bit ev, fv;
      logic [AW-1:0] ea, fa;
      ev = ($urandom_range(2) == 0);
      fv = ($urandom_range(2) == 0);
      ea = pick_addr();
      fa = (ev && $urandom_range(1) == 1) ? ea : pick_addr();
      step(ev, ea, fv, fa);
    end
    drain(2000);

    // Fill the queue behind a stalled request, then reset mid-request.
    filt_stall = 1'b1;
    repeat (6) step(1'b1, $urandom, 1'b1, $urandom);
    chk("full_queued", exp_req.size(), DEPTH - 1);
    chk("pre_reset_busy", bif.eaf_insert | bif.eaf_test, 1);
    bif.evict_valid = 1'b0;
    bif.fill_valid  = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_reset_outputs", |{bif.fill_done, bif.fill_done_addr, bif.fill_priority, bif.fill_hit,
                                 bif.eaf_addr, bif.eaf_insert, bif.eaf_test, bif.timeout_err}, 0);
    chk("async_reset_ready", {bif.evict_ready, bif.fill_ready}, 2'b11);
    exp_req.delete();
    exp_out.delete();
    filt_stall = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) step(1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b1, 32'h0000_1040);
    drain(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
